// File: rtl/median_filter_stream_pkg.sv
// Shared constants and helpers for the streaming median filter.
// Optional feature macro: MEDIAN_MINMAX_EN (adds window min/max outputs).
package median_filter_stream_pkg;

  // Largest supported window length.
  localparam int MED_WINDOW_MAX = 15;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Rank of the median element within a window of length w.
  function automatic int med_idx(input int w);
    return (w - 1) / 2;
  endfunction

endpackage

// File: rtl/median_filter_stream_rank_cell.sv
// Rank of one window element: how many elements sort before it.
// Equal values are ordered by index so that all ranks come out unique.
module median_rank_cell
  import median_filter_stream_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int WINDOW = 5,
  parameter int IDX_W  = clog2(WINDOW)
) (
  input  logic [DATA_W-1:0]        i_elem,
  input  logic [IDX_W-1:0]         i_idx,
  input  logic [WINDOW*DATA_W-1:0] i_win,
  output logic [IDX_W-1:0]         o_rank
);

  // Count strictly smaller elements plus equal elements at a lower index.
  always_comb begin
    o_rank = '0;
    for (int j = 0; j < WINDOW; j++) begin
      if ((i_win[j*DATA_W +: DATA_W] < i_elem) ||
          ((IDX_W'(j) < i_idx) && (i_win[j*DATA_W +: DATA_W] == i_elem))) begin
        o_rank = o_rank + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/median_filter_stream.sv
// Streaming sliding-window median filter with valid/ready on both sides.
// Optional feature macro: MEDIAN_MINMAX_EN (adds registered out_min/out_max).
module median_filter_stream
  import median_filter_stream_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int WINDOW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_median
`ifdef MEDIAN_MINMAX_EN
  ,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max
`endif
);

  localparam int IDX_W   = clog2(WINDOW);
  localparam int FILL_W  = clog2(WINDOW + 1);
  localparam int MED_IDX = med_idx(WINDOW);

  // Only odd windows in the supported range have a unique middle element.
  if ((WINDOW % 2 == 0) || (WINDOW < 3) || (WINDOW > MED_WINDOW_MAX)) begin : g_bad_window
    $error("median_filter_stream: WINDOW must be odd and within 3..15");
  end

  logic [DATA_W-1:0]        r_win [WINDOW];
  logic [FILL_W-1:0]        r_fill;
  logic                     r_out_valid;
  logic [DATA_W-1:0]        r_out_median;

  logic [DATA_W-1:0]        w_win_next [WINDOW];
  logic [WINDOW*DATA_W-1:0] w_win_bus;
  logic [IDX_W-1:0]         w_rank [WINDOW];
  logic [DATA_W-1:0]        w_median;
  logic                     w_accept;
  logic [FILL_W-1:0]        w_fill_next;
  logic                     w_qual;

  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_fill_next = (r_fill == FILL_W'(WINDOW)) ? r_fill : r_fill + FILL_W'(1);
  assign w_qual      = w_accept && (w_fill_next == FILL_W'(WINDOW));

  // The median is ranked over the window as it will look after this accept.
  for (genvar gi = 0; gi < WINDOW; gi++) begin : g_cell
    if (gi == 0) begin : g_head
      assign w_win_next[gi] = in_data;
    end else begin : g_tail
      assign w_win_next[gi] = r_win[gi-1];
    end
    assign w_win_bus[gi*DATA_W +: DATA_W] = w_win_next[gi];

    median_rank_cell #(
      .DATA_W (DATA_W),
      .WINDOW (WINDOW),
      .IDX_W  (IDX_W)
    ) u_rank (
      .i_elem (w_win_next[gi]),
      .i_idx  (IDX_W'(gi)),
      .i_win  (w_win_bus),
      .o_rank (w_rank[gi])
    );
  end

`ifdef MEDIAN_MINMAX_EN
  logic [DATA_W-1:0] w_min;
  logic [DATA_W-1:0] w_max;
  logic [DATA_W-1:0] r_out_min;
  logic [DATA_W-1:0] r_out_max;

  // Pick median, min and max by matching unique ranks (one-hot select).
  always_comb begin
    w_median = '0;
    w_min    = '0;
    w_max    = '0;
    for (int i = 0; i < WINDOW; i++) begin
      if (w_rank[i] == IDX_W'(MED_IDX))    w_median = w_median | w_win_next[i];
      if (w_rank[i] == '0)                 w_min    = w_min    | w_win_next[i];
      if (w_rank[i] == IDX_W'(WINDOW - 1)) w_max    = w_max    | w_win_next[i];
    end
  end

  // Min/max share the median's load condition; valid and hold come for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_min <= '0;
      r_out_max <= '0;
    end else if (!clear && w_qual) begin
      r_out_min <= w_min;
      r_out_max <= w_max;
    end
  end

  assign out_min = r_out_min;
  assign out_max = r_out_max;
`else
  // Pick the median by matching its unique rank (one-hot select).
  always_comb begin
    w_median = '0;
    for (int i = 0; i < WINDOW; i++) begin
      if (w_rank[i] == IDX_W'(MED_IDX)) w_median = w_median | w_win_next[i];
    end
  end
`endif

  // Window shift register and saturating fill count; clear beats an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WINDOW; k++) r_win[k] <= '0;
      r_fill <= '0;
    end else if (clear) begin
      for (int k = 0; k < WINDOW; k++) r_win[k] <= '0;
      r_fill <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < WINDOW; k++) r_win[k] <= w_win_next[k];
      r_fill <= w_fill_next;
    end
  end

  // Output register: reload on a full-window accept, else drop once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_median <= '0;
    end else if (clear) begin
      r_out_valid  <= 1'b0;
    end else if (w_qual) begin
      r_out_valid  <= 1'b1;
      r_out_median <= w_median;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_median = r_out_median;

endmodule

// File: tb/tb_median_filter_stream.sv
// Directed bench for median_filter_stream (DATA_W=4, WINDOW=5).
// Define MEDIAN_MINMAX_EN to also exercise out_min/out_max.
module tb_median_filter_stream;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_median;
`ifdef MEDIAN_MINMAX_EN
  logic [3:0] out_min;
  logic [3:0] out_max;
`endif

  int n_total;
  int n_bad;

  median_filter_stream #(
    .DATA_W (4),
    .WINDOW (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_median (out_median)
`ifdef MEDIAN_MINMAX_EN
    ,
    .out_min    (out_min),
    .out_max    (out_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Present one sample for one clock edge, then sample 1 time unit later.
  task automatic push(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [3:0] fill_v [5];
  logic [3:0] slide_v [3];
  logic [3:0] slide_m [3];

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    fill_v  = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5};
    slide_v = '{4'd9, 4'd2, 4'd6};
    slide_m = '{4'd4, 4'd4, 4'd5};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_median", out_median, 0);
    rst_n = 1'b1;
    #1;
    check_val("rst_in_ready", in_ready, 1);

    // Fill: nothing until the 5th accept
    for (int i = 0; i < 5; i++) begin
      push(fill_v[i]);
      if (i < 4) check_val($sformatf("fill_novalid_%0d", i), out_valid, 0);
    end
    check_val("fill_valid", out_valid, 1);
    check_val("fill_median", out_median, 3);
`ifdef MEDIAN_MINMAX_EN
    check_val("fill_min", out_min, 1);
    check_val("fill_max", out_max, 5);
`endif

    // Sliding at full throughput
    for (int i = 0; i < 3; i++) begin
      push(slide_v[i]);
      check_val($sformatf("slide_valid_%0d", i), out_valid, 1);
      check_val($sformatf("slide_median_%0d", i), out_median, slide_m[i]);
    end

    // Ties
    for (int i = 0; i < 5; i++) push(4'd7);
    check_val("tie_all7", out_median, 7);
    push(4'd0);
    check_val("tie_with0", out_median, 7);
    push(4'd15);
    push(4'd15);
    check_val("tie_15_15", out_median, 7);

    // Backpressure: window 15,15,0,7,7 held, then 14 enters -> 0,7,14,15,15
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'd14;
    #1;
    check_val("bp_in_ready_low", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("bp_hold_valid_%0d", i), out_valid, 1);
      check_val($sformatf("bp_hold_median_%0d", i), out_median, 7);
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_in_ready_high", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("bp_next_valid", out_valid, 1);
    check_val("bp_next_median", out_median, 14);
    @(posedge clk);
    #1;
    check_val("bp_drain_valid", out_valid, 0);

    // Clear discards a held output
    push(4'd6);
    check_val("clr_pre_valid", out_valid, 1);
    out_ready = 1'b0;
    clear     = 1'b1;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    out_ready = 1'b1;
    check_val("clr_discard_valid", out_valid, 0);

    // Three fills, then clear with a same-cycle sample that must be dropped
    for (int i = 0; i < 3; i++) push(4'd2);
    check_val("clr_partial_valid", out_valid, 0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'd9;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push(4'(i));
      if (i < 5) check_val($sformatf("clr_refill_novalid_%0d", i), out_valid, 0);
    end
    check_val("clr_refill_valid", out_valid, 1);
    check_val("clr_refill_median", out_median, 3);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_val("arst_out_valid", out_valid, 0);
    check_val("arst_out_median", out_median, 0);
`ifdef MEDIAN_MINMAX_EN
    check_val("arst_out_min", out_min, 0);
    check_val("arst_out_max", out_max, 0);
`endif
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check_val("arst_in_ready", in_ready, 1);
    push(4'd7);
    push(4'd3);
    push(4'd9);
    push(4'd1);
    check_val("arst_refill_novalid", out_valid, 0);
    push(4'd8);
    check_val("arst_refill_valid", out_valid, 1);
    check_val("arst_refill_median", out_median, 7);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #20000;
    $display("FAIL timeout: got 0, want 1");
    $fatal(1, "timeout");
  end

endmodule
